// File: rtl/sleep_ctrl_pkg.sv
// Shared types and constants for the core sleep controller.
// The wake latency counter is WCNT_W bits wide, which bounds WAKE_LAT to 1..15.
package sleep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  localparam int unsigned WAKE_LAT_MIN = 1;
  localparam int unsigned WAKE_LAT_MAX = 15;
  localparam int unsigned WCNT_W       = 4;

  // Out-of-range latencies are clamped so the counter load always fits.
  function automatic logic [WCNT_W-1:0] wake_lat_load(input int unsigned lat);
    int unsigned l;
    l = lat;
    if (l < WAKE_LAT_MIN) l = WAKE_LAT_MIN;
    if (l > WAKE_LAT_MAX) l = WAKE_LAT_MAX;
    return WCNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/clock_gate.sv
// Latch-based glitch-free clock gate: the enable is captured while the clock
// is low and held while it is high.
module clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic gclk_o
);

  logic en_l;

  always_latch begin
    if (!clk_i) en_l = en_i | test_en_i;
  end

  assign gclk_o = clk_i & en_l;

endmodule

// File: rtl/sleep_ctrl.sv
// Core sleep controller: idle hold-off counter, RUN/DRAIN/SLEEP/WAKE FSM,
// maskable wake channels with source capture, and the gated core clock.
module sleep_ctrl
  import sleep_ctrl_pkg::*;
#(
  parameter int unsigned N_WAKE     = 4,
  parameter int unsigned HOLD_W     = 8,
  parameter int unsigned HOLD_RESET = 38,
  parameter int unsigned WAKE_LAT   = 2
) (
  input  logic              clk_ungated_i,
  input  logic              reset,
  input  logic              scan_cg_en_i,
  input  logic [N_WAKE-1:0] wake_i,
  input  logic [N_WAKE-1:0] wake_mask_i,
  input  logic              busy_i,
  input  logic [HOLD_W-1:0] hold_cfg_i,
  output logic              clk_gated_o,
  output logic              core_sleep_o,
  output logic              core_busy_o,
  output logic [N_WAKE-1:0] wake_src_o,
  output logic              wake_evt_o,
  output state_e            dbg_state_o
);

  localparam logic [WCNT_W-1:0] WCNT_LOAD = wake_lat_load(WAKE_LAT);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [N_WAKE-1:0]   wake_src_q, wake_src_d;
  logic                wake_evt_q, wake_evt_d;
  logic                clk_en_q, clk_en_d;

  logic [N_WAKE-1:0]   wake_vec;
  logic                wake_hit;
  logic                act;

  assign wake_vec = wake_i & wake_mask_i;
  assign wake_hit = |wake_vec;
  assign act      = busy_i | wake_hit;

  always_ff @(posedge clk_ungated_i or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      cnt_q      <= HOLD_W'(HOLD_RESET);
      wcnt_q     <= '0;
      wake_src_q <= '0;
      wake_evt_q <= 1'b0;
      clk_en_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      wake_src_q <= wake_src_d;
      wake_evt_q <= wake_evt_d;
      clk_en_q   <= clk_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (!act && cnt_q == '0) state_d = ST_DRAIN;
      ST_DRAIN: state_d = act ? ST_RUN : ST_SLEEP;
      // busy_i alone cannot wake: the core has no clock to raise it with.
      ST_SLEEP: if (wake_hit) state_d = ST_WAKE;
      ST_WAKE:  if (wcnt_q == '0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    wake_src_d = wake_src_q;
    wake_evt_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (act)              cnt_d = hold_cfg_i;
        else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      ST_DRAIN: if (act) cnt_d = hold_cfg_i;
      ST_SLEEP: begin
        if (wake_hit) begin
          wake_src_d = wake_vec;
          wake_evt_d = 1'b1;
          wcnt_d     = WCNT_LOAD;
        end
      end
      ST_WAKE: begin
        if (wcnt_q == '0) cnt_d  = hold_cfg_i;
        else              wcnt_d = wcnt_q - 1'b1;
      end
      default: ;
    endcase
    clk_en_d = (state_d != ST_SLEEP);
  end

  assign core_sleep_o = (state_q == ST_SLEEP);
  assign core_busy_o  = (state_q != ST_SLEEP) | wake_hit;
  assign wake_src_o   = wake_src_q;
  assign wake_evt_o   = wake_evt_q;
  assign dbg_state_o  = state_q;

  clock_gate u_clock_gate (
    .clk_i     (clk_ungated_i),
    .en_i      (clk_en_q),
    .test_en_i (scan_cg_en_i),
    .gclk_o    (clk_gated_o)
  );

endmodule

// File: tb/tb_sleep_ctrl.sv
// Self-checking bench for sleep_ctrl: directed scenarios plus a randomized run
// checked against an idle-count based reference model.
module tb_sleep_ctrl;
  import sleep_ctrl_pkg::*;

  localparam int N_WAKE     = 4;
  localparam int HOLD_W     = 8;
  localparam int HOLD_RESET = 5;
  localparam int WAKE_LAT   = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              scan_cg_en_i;
  logic [N_WAKE-1:0] wake_i;
  logic [N_WAKE-1:0] wake_mask_i;
  logic              busy_i;
  logic [HOLD_W-1:0] hold_cfg_i;
  logic              clk_gated_o;
  logic              core_sleep_o;
  logic              core_busy_o;
  logic [N_WAKE-1:0] wake_src_o;
  logic              wake_evt_o;
  state_e            dbg_state_o;

  int checks = 0;
  int errors = 0;
  int gedges = 0;

  always #5 clk = ~clk;

  sleep_ctrl #(
    .N_WAKE(N_WAKE), .HOLD_W(HOLD_W), .HOLD_RESET(HOLD_RESET), .WAKE_LAT(WAKE_LAT)
  ) dut (
    .clk_ungated_i(clk),
    .reset        (reset),
    .scan_cg_en_i (scan_cg_en_i),
    .wake_i       (wake_i),
    .wake_mask_i  (wake_mask_i),
    .busy_i       (busy_i),
    .hold_cfg_i   (hold_cfg_i),
    .clk_gated_o  (clk_gated_o),
    .core_sleep_o (core_sleep_o),
    .core_busy_o  (core_busy_o),
    .wake_src_o   (wake_src_o),
    .wake_evt_o   (wake_evt_o),
    .dbg_state_o  (dbg_state_o)
  );

  always @(posedge clk_gated_o) gedges++;

  // Reference model: idle cycles since the last activity against the hold
  // value captured at that activity; sleep and wake tracked as flags.
  int                m_idle;
  int                m_hold;
  bit                m_asleep;
  int                m_wake_left;
  logic [N_WAKE-1:0] m_src;
  bit                m_evt;

  always @(posedge clk or posedge reset) begin
    logic [N_WAKE-1:0] v;
    if (reset) begin
      m_idle = 0; m_hold = HOLD_RESET; m_asleep = 0;
      m_wake_left = 0; m_src = '0; m_evt = 0;
    end else begin
      v = wake_i & wake_mask_i;
      m_evt = 0;
      if (m_asleep) begin
        if (v != 0) begin
          m_asleep = 0; m_wake_left = WAKE_LAT; m_src = v; m_evt = 1;
        end
      end else if (m_wake_left > 0) begin
        m_wake_left--;
        if (m_wake_left == 0) begin m_idle = 0; m_hold = int'(hold_cfg_i); end
      end else if (busy_i || v != 0) begin
        m_idle = 0; m_hold = int'(hold_cfg_i);
      end else if (m_idle == m_hold + 1) begin
        m_asleep = 1;
      end else begin
        m_idle++;
      end
    end
  end

  function automatic state_e exp_state();
    if (m_asleep)               return ST_SLEEP;
    if (m_wake_left > 0)        return ST_WAKE;
    if (m_idle <= m_hold)       return ST_RUN;
    return ST_DRAIN;
  endfunction

  task automatic test_reset();
    reset = 1'b1; scan_cg_en_i = 0; wake_i = '0; wake_mask_i = '1;
    busy_i = 0; hold_cfg_i = 8'd5;
    repeat (2) @(negedge clk);
    checks++; if (dbg_state_o !== ST_RUN) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state_o, ST_RUN); end
    checks++; if (core_sleep_o !== 1'b0) begin errors++; $display("FAIL reset_sleep got %b want 0", core_sleep_o); end
    checks++; if (core_busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", core_busy_o); end
    checks++; if (wake_src_o !== 4'b0000) begin errors++; $display("FAIL reset_src got %b want 0000", wake_src_o); end
    checks++; if (wake_evt_o !== 1'b0) begin errors++; $display("FAIL reset_evt got %b want 0", wake_evt_o); end
    reset = 1'b0;
    gedges = 0;
  endtask

  task automatic test_idle_timeout();
    state_e want;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      want = (k <= 5) ? ST_RUN : (k == 6) ? ST_DRAIN : ST_SLEEP;
      checks++; if (dbg_state_o !== want) begin errors++; $display("FAIL idle_state cyc %0d got %0d want %0d", k, dbg_state_o, want); end
      checks++; if (core_sleep_o !== (k >= 7)) begin errors++; $display("FAIL idle_sleep cyc %0d got %b want %b", k, core_sleep_o, (k >= 7)); end
    end
    checks++; if (gedges != 7) begin errors++; $display("FAIL idle_gated_edges got %0d want 7", gedges); end
  endtask

  task automatic test_masked_wake();
    int g0;
    wake_i = 4'b0010; wake_mask_i = 4'b1101;
    #1;
    checks++; if (core_busy_o !== 1'b0) begin errors++; $display("FAIL masked_busy got %b want 0", core_busy_o); end
    g0 = gedges;
    repeat (4) begin
      @(negedge clk);
      checks++; if (dbg_state_o !== ST_SLEEP || wake_evt_o !== 1'b0) begin errors++; $display("FAIL masked_stay state %0d evt %b want SLEEP evt 0", dbg_state_o, wake_evt_o); end
    end
    checks++; if (gedges != g0) begin errors++; $display("FAIL masked_edges got %0d want %0d", gedges, g0); end
  endtask

  task automatic test_unmasked_wake();
    int g0;
    wake_i = 4'b1010; wake_mask_i = 4'b1111;
    #1;
    checks++; if (core_busy_o !== 1'b1) begin errors++; $display("FAIL wake_busy_early got %b want 1", core_busy_o); end
    g0 = gedges;
    @(negedge clk);
    checks++; if (wake_evt_o !== 1'b1) begin errors++; $display("FAIL wake_evt got %b want 1", wake_evt_o); end
    checks++; if (wake_src_o !== 4'b1010) begin errors++; $display("FAIL wake_src got %b want 1010", wake_src_o); end
    checks++; if (dbg_state_o !== ST_WAKE) begin errors++; $display("FAIL wake_state1 got %0d want %0d", dbg_state_o, ST_WAKE); end
    checks++; if (gedges != g0) begin errors++; $display("FAIL wake_no_edge_w1 got %0d want %0d", gedges, g0); end
    wake_i = '0; wake_mask_i = '0;
    @(negedge clk);
    checks++; if (gedges != g0 + 1) begin errors++; $display("FAIL wake_first_edge got %0d want %0d", gedges, g0 + 1); end
    checks++; if (wake_evt_o !== 1'b0 || dbg_state_o !== ST_WAKE) begin errors++; $display("FAIL wake_state2 evt %b state %0d want 0/WAKE", wake_evt_o, dbg_state_o); end
    @(negedge clk);
    checks++; if (dbg_state_o !== ST_RUN) begin errors++; $display("FAIL wake_run got %0d want %0d", dbg_state_o, ST_RUN); end
    checks++; if (wake_src_o !== 4'b1010) begin errors++; $display("FAIL wake_src_hold got %b want 1010", wake_src_o); end
    wake_mask_i = '1; hold_cfg_i = 8'd2;
  endtask

  task automatic reach_sleep();
    int n = 0;
    while (core_sleep_o !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks++; if (core_sleep_o !== 1'b1) begin errors++; $display("FAIL reach_sleep timeout got %b want 1", core_sleep_o); end
  endtask

  task automatic test_scan();
    int g0;
    g0 = gedges;
    scan_cg_en_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++; if (dbg_state_o !== ST_SLEEP) begin errors++; $display("FAIL scan_state got %0d want %0d", dbg_state_o, ST_SLEEP); end
    end
    scan_cg_en_i = 1'b0;
    @(negedge clk);
    checks++; if (gedges != g0 + 4) begin errors++; $display("FAIL scan_edges got %0d want %0d", gedges, g0 + 4); end
  endtask

  task automatic test_async_reset();
    int g0;
    checks++; if (wake_src_o !== 4'b1010) begin errors++; $display("FAIL src_before_reset got %b want 1010", wake_src_o); end
    @(posedge clk); #2;
    g0 = gedges;
    reset = 1'b1; #1;
    checks++; if (core_sleep_o !== 1'b0 || dbg_state_o !== ST_RUN) begin errors++; $display("FAIL areset_state sleep %b state %0d want 0/RUN", core_sleep_o, dbg_state_o); end
    checks++; if (wake_src_o !== 4'b0000) begin errors++; $display("FAIL areset_src got %b want 0000", wake_src_o); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (gedges != g0) begin errors++; $display("FAIL areset_no_glitch got %0d want %0d", gedges, g0); end
    @(negedge clk);
    checks++; if (gedges != g0 + 1) begin errors++; $display("FAIL areset_clock_back got %0d want %0d", gedges, g0 + 1); end
  endtask

  task automatic test_drain_race();
    hold_cfg_i = 8'd0; busy_i = 1'b1;
    @(negedge clk);
    busy_i = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state_o !== ST_DRAIN) begin errors++; $display("FAIL race_drain got %0d want %0d", dbg_state_o, ST_DRAIN); end
    wake_i = 4'b0001; wake_mask_i = 4'b1111; hold_cfg_i = 8'd3;
    @(negedge clk);
    checks++; if (dbg_state_o !== ST_RUN || core_sleep_o !== 1'b0) begin errors++; $display("FAIL race_run state %0d sleep %b want RUN/0", dbg_state_o, core_sleep_o); end
    checks++; if (wake_evt_o !== 1'b0) begin errors++; $display("FAIL race_evt got %b want 0", wake_evt_o); end
    wake_i = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (dbg_state_o !== ((k == 4) ? ST_DRAIN : ST_RUN)) begin errors++; $display("FAIL race_reload cyc %0d got %0d", k, dbg_state_o); end
    end
  endtask

  task automatic test_random();
    state_e es;
    bit     exp_busy, exp_edge;
    int     g0;
    for (int i = 0; i < 600; i++) begin
      busy_i       = ($urandom_range(0, 9) == 0);
      wake_i       = ($urandom_range(0, 11) == 0) ? N_WAKE'($urandom_range(1, 15)) : '0;
      wake_mask_i  = N_WAKE'($urandom_range(0, 15));
      hold_cfg_i   = HOLD_W'($urandom_range(0, 6));
      scan_cg_en_i = ($urandom_range(0, 19) == 0);
      #1;
      es       = exp_state();
      exp_busy = (es != ST_SLEEP) || ((wake_i & wake_mask_i) != 0);
      exp_edge = (es != ST_SLEEP) || scan_cg_en_i;
      checks++; if (core_busy_o !== exp_busy) begin errors++; $display("FAIL rnd_busy it %0d got %b want %b", i, core_busy_o, exp_busy); end
      g0 = gedges;
      @(negedge clk);
      es = exp_state();
      checks++; if (dbg_state_o !== es) begin errors++; $display("FAIL rnd_state it %0d got %0d want %0d", i, dbg_state_o, es); end
      checks++; if (core_sleep_o !== (es == ST_SLEEP)) begin errors++; $display("FAIL rnd_sleep it %0d got %b want %b", i, core_sleep_o, (es == ST_SLEEP)); end
      checks++; if (wake_evt_o !== m_evt) begin errors++; $display("FAIL rnd_evt it %0d got %b want %b", i, wake_evt_o, m_evt); end
      checks++; if (wake_src_o !== m_src) begin errors++; $display("FAIL rnd_src it %0d got %b want %b", i, wake_src_o, m_src); end
      checks++; if (gedges - g0 != int'(exp_edge)) begin errors++; $display("FAIL rnd_gated it %0d got %0d want %0d", i, gedges - g0, exp_edge); end
    end
    scan_cg_en_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_timeout();
    test_masked_wake();
    test_unmasked_wake();
    reach_sleep();
    test_scan();
    test_async_reset();
    test_drain_race();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sleep_ctrl.md
# sleep_ctrl

Parametrised core sleep controller that replaces the fixed 38-stage busy shift register with a programmable idle hold-off counter. It adds multiple maskable wake channels, an explicit sleep/wake state machine and wake-source reporting. It sits between the ungated core clock and the core, drives the gated core clock through the team's latch-based clock gate cell, and reports sleep/busy status to the system.

## Interface
- N_WAKE, 4, number of independent wake request channels
- HOLD_W, 8, width of the hold-off counter and `hold_cfg_i`
- HOLD_RESET, 38, hold-off count loaded at reset
- WAKE_LAT, 2, cycles spent in WAKE before returning to RUN (1..15)

Ports:
- clk_ungated_i  in  1  free-running core clock
- reset  in  1  asynchronous, active-high reset
- scan_cg_en_i  in  1  scan override; forces the gated clock on
- wake_i  in  N_WAKE  level wake requests, one per channel
- wake_mask_i  in  N_WAKE  1 = channel enabled
- busy_i  in  1  core activity (new instruction, multi-cycle unit busy)
- hold_cfg_i  in  HOLD_W  idle cycles tolerated before sleeping; sampled on each reload
- clk_gated_o  out  1  gated core clock
- core_sleep_o  out  1  high in SLEEP
- core_busy_o  out  1  combinational: state != SLEEP, or any unmasked wake
- wake_src_o  out  N_WAKE  unmasked wake vector captured at the last wake
- wake_evt_o  out  1  one-cycle pulse on the SLEEP->WAKE transition

## Operation
- `act` = busy_i | |(wake_i & wake_mask_i); `wake` = |(wake_i & wake_mask_i).
- States: RUN, DRAIN, SLEEP, WAKE.
- RUN
  - If act, reload `cnt <= hold_cfg_i`.
  - Else if cnt != 0, `cnt--`.
  - Else (cnt == 0), go to DRAIN.
- DRAIN (clock still enabled, one cycle)
  - If act, go to RUN and reload cnt.
  - Else go to SLEEP.
- SLEEP
  - If wake, go to WAKE, capture `wake_src_o <= wake_i & wake_mask_i`, pulse wake_evt_o, and load `wcnt <= WAKE_LAT-1`.
  - busy_i alone does not wake: the core clock is stopped.
- WAKE
  - If wcnt == 0, go to RUN and reload `cnt <= hold_cfg_i`.
  - Else `wcnt--`.
- Clock enable: `clk_en_q <= (next_state != SLEEP)`, registered. Gate enable = clk_en_q | scan_cg_en_i.
- Reset values:
  - state RUN, cnt HOLD_RESET, clk_en_q 1, wcnt 0
  - wake_src_o 0, wake_evt_o 0, core_sleep_o 0, core_busy_o 1
  - The gate latch is transparent while clk is low, so clk_gated_o follows the clock after reset.
- Boundary conditions:
  - hold_cfg_i = 0: RUN->DRAIN on the first idle cycle.
  - hold_cfg_i changes mid-count: takes effect only at the next reload.
  - wake in the same cycle as DRAIN->SLEEP: act is true, so the controller returns to RUN and never sleeps.
  - wake_mask_i cleared while in WAKE: no effect; the WAKE sequence completes.
  - Reset asserted mid-sleep: immediate return to RUN with the clock enabled.
- wake_src_o holds its value until the next SLEEP->WAKE transition.

## Timing
- Idle to sleep, counting from the last act cycle t with cfg = H: DRAIN at t+H+1, SLEEP at t+H+2. Last gated rising edge is at t+H+2; no gated edges from t+H+3.
- Wake asserted at cycle w while in SLEEP:
  - WAKE state, clk_en_q = 1 and wake_evt_o = 1 at w+1.
  - First gated rising edge at w+2 (the latch opens in the low phase after w+1).
  - RUN at w+WAKE_LAT+1.
- core_busy_o rises combinationally in cycle w (zero latency), giving upstream logic early notice.
- The gated clock is glitch-free: the enable changes only on posedge, and the latch is transparent only while the clock is low.

## Structure
- Package `sleep_ctrl_pkg`: state enum (RUN, DRAIN, SLEEP, WAKE) and the WAKE_LAT range check constant.
- One sub-module: the team's existing latch-based `clock_gate` cell, instantiated unchanged.
- Counter, FSM and wake capture live in `sleep_ctrl` itself.

## Test plan
- Idle timeout: reset, hold_cfg_i = 5, busy_i low -> core_sleep_o at cycle 7, clk_gated_o flat from cycle 8; the gated clock gives 7 edges after reset.
- Masked wake: in SLEEP, wake_i = 4'b0010 with wake_mask_i = 4'b1101 -> stays in SLEEP, core_busy_o = 0, no wake_evt_o.
- Unmasked wake (WAKE_LAT = 2): in SLEEP, wake_i = 4'b1010 with mask 4'b1111 at cycle w -> wake_evt_o at w+1, wake_src_o = 4'b1010, first gated edge at w+2, RUN at w+3.
- Race at DRAIN: hold_cfg_i = 0, busy_i drops, wake_i[0] pulses in the DRAIN cycle -> returns to RUN, core_sleep_o never asserts, cnt reloaded.
- Scan override: in SLEEP, scan_cg_en_i = 1 -> clk_gated_o toggles every cycle while state stays SLEEP.
- Async reset during SLEEP: reset pulsed mid-cycle -> core_sleep_o = 0 and wake_src_o = 0 immediately, gated clock running on the next high phase.
